// File: rtl/fir_tdm_filter.sv
// Programmable N_TAPS FIR filter built around one shared multiply-accumulate unit.
// Each accepted sample takes N_TAPS MAC cycles and one output cycle; the result is rounded and saturated.
module fir_tdm_filter #(
  parameter int N_TAPS     = 8,
  parameter int NB_INPUT   = 14,
  parameter int NBF_INPUT  = 13,
  parameter int NB_COEFF   = 8,
  parameter int NBF_COEFF  = 7,
  parameter int NB_OUTPUT  = 14,
  parameter int NBF_OUTPUT = 13,
  parameter int ROUND      = 1
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_clear,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [NB_INPUT-1:0]         i_is_data,
  input  logic                        i_coeff_we,
  input  logic [$clog2(N_TAPS)-1:0]   i_coeff_addr,
  input  logic [NB_COEFF-1:0]         i_coeff_data,
  output logic                        o_valid,
  output logic [NB_OUTPUT-1:0]        o_os_data,
  output logic                        o_sat
);

  localparam int CW = $clog2(N_TAPS);
  localparam int PW = NB_INPUT + NB_COEFF;
  localparam int AW = PW + CW;
  localparam int D  = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;

  localparam logic signed [AW:0] RND =
    (ROUND != 0 && D > 0) ? ((AW+1)'(1) << ((D > 0) ? D - 1 : 0)) : '0;
  localparam logic signed [AW:0] OMAX = {{(AW+2-NB_OUTPUT){1'b0}}, {(NB_OUTPUT-1){1'b1}}};
  localparam logic signed [AW:0] OMIN = {{(AW+2-NB_OUTPUT){1'b1}}, {(NB_OUTPUT-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic signed [NB_INPUT-1:0] x [N_TAPS];
  logic signed [NB_COEFF-1:0] c [N_TAPS];
  logic signed [AW-1:0]       acc;
  logic [CW-1:0]              cnt;

  logic                       accept;
  logic                       last_tap;
  logic                       flush;
  logic                       coeff_wr;
  logic signed [PW-1:0]       prod;
  logic signed [AW:0]         rounded;
  logic signed [AW:0]         shifted;
  logic [NB_OUTPUT-1:0]       sat_data;
  logic                       sat_flag;

  assign o_ready  = (state == IDLE) && i_en;
  assign accept   = i_valid && o_ready && !i_clear;
  assign flush    = i_en && i_clear;
  assign last_tap = (cnt == CW'(N_TAPS - 1));
  assign coeff_wr = i_en && !i_clear && (state == IDLE) && i_coeff_we
                    && (int'(i_coeff_addr) < N_TAPS);

  // State register and next-state logic
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_en) begin
      if (i_clear) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE:    if (i_valid) state_next = MAC;
          MAC:     if (last_tap) state_next = OUT;
          OUT:     state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // Delay line and coefficient bank, one register per tap
  generate
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          x[gi] <= '0;
        end else if (flush) begin
          x[gi] <= '0;
        end else if (accept) begin
          if (gi == 0) x[gi] <= i_is_data;
          else         x[gi] <= x[(gi > 0) ? gi - 1 : 0];
        end
      end

      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          c[gi] <= '0;
        end else if (coeff_wr && (int'(i_coeff_addr) == gi)) begin
          c[gi] <= i_coeff_data;
        end
      end
    end
  endgenerate

  assign prod = c[cnt] * x[cnt];

  // One guard bit above the accumulator absorbs the rounding offset
  assign rounded = {acc[AW-1], acc} + RND;
  assign shifted = rounded >>> D;

  always_comb begin
    sat_flag = 1'b0;
    sat_data = shifted[NB_OUTPUT-1:0];
    if (shifted > OMAX) begin
      sat_flag = 1'b1;
      sat_data = OMAX[NB_OUTPUT-1:0];
    end else if (shifted < OMIN) begin
      sat_flag = 1'b1;
      sat_data = OMIN[NB_OUTPUT-1:0];
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      o_valid   <= 1'b0;
      o_os_data <= '0;
      o_sat     <= 1'b0;
    end else if (i_en) begin
      if (i_clear) begin
        acc     <= '0;
        cnt     <= '0;
        o_valid <= 1'b0;
      end else begin
        o_valid <= 1'b0;
        case (state)
          IDLE: begin
            if (i_valid) begin
              acc <= '0;
              cnt <= '0;
            end
          end
          MAC: begin
            acc <= acc + {{(AW-PW){prod[PW-1]}}, prod};
            if (!last_tap) cnt <= cnt + CW'(1);
          end
          OUT: begin
            o_valid   <= 1'b1;
            o_os_data <= sat_data;
            o_sat     <= sat_flag;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fir_tdm_filter.md
Name: fir_tdm_filter

Overview:
- Parametrised successor to the fixed 4-tap lowpass FIR.
- Has N_TAPS runtime-programmable coefficients, a valid/ready input handshake, and one time-multiplexed multiply-accumulate unit.
- Output is rounded and saturated, with a saturation flag.
- Sits between the sample source and the downstream gain/AGC stage. Intended for sample rates of at most clk/(N_TAPS+2).

Parameters:
- N_TAPS, 8: number of taps; must be ≥ 2.
- NB_INPUT, 14: input sample width, signed.
- NBF_INPUT, 13: input fractional bits.
- NB_COEFF, 8: coefficient width, signed.
- NBF_COEFF, 7: coefficient fractional bits.
- NB_OUTPUT, 14: output width, signed.
- NBF_OUTPUT, 13: output fractional bits; must satisfy NBF_INPUT+NBF_COEFF ≥ NBF_OUTPUT.
- ROUND, 1: 1 = round half up on discarded bits; 0 = truncate.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_en, in, 1: enable; 0 freezes all state.
- i_clear, in, 1: synchronous flush of the delay line and datapath.
- i_valid, in, 1: input sample valid.
- o_ready, out, 1: block can accept a sample.
- i_is_data, in, NB_INPUT: input sample.
- i_coeff_we, in, 1: coefficient write strobe.
- i_coeff_addr, in, clog2(N_TAPS): coefficient index (0 = newest sample tap).
- i_coeff_data, in, NB_COEFF: coefficient value.
- o_valid, out, 1: one-cycle output strobe.
- o_os_data, out, NB_OUTPUT: filtered sample.
- o_sat, out, 1: o_os_data was clipped; qualified by o_valid.

Behaviour:
Reset and state:
- i_rst_n=0 (async) clears the delay line, all coefficients, accumulator, tap counter, o_os_data, o_valid and o_sat to 0.
- FSM goes to IDLE, so o_ready=1 as soon as i_rst_n is released.
- FSM states are IDLE, MAC, OUT.
- o_ready = (state==IDLE) && i_en.

Accept and latency:
- A sample is accepted on an edge where i_valid && o_ready.
- At that edge: x[0] ← i_is_data, x[k] ← x[k-1], accumulator ← 0, tap counter ← 0, state → MAC.
- MAC lasts N_TAPS edges. Each edge does acc += c[k]*x[k] with k = counter, then counter++. After k = N_TAPS-1 the state goes to OUT.
- OUT lasts one edge: o_os_data and o_sat are registered, o_valid ← 1, state → IDLE.
- o_valid is high for exactly one cycle, the first IDLE cycle. o_os_data holds its value until the next OUT.
- Latency is accept edge + N_TAPS+1 edges. Minimum sample period is N_TAPS+2 cycles.

Arithmetic:
- Product width is NB_INPUT+NB_COEFF, full precision.
- Accumulator width is NB_INPUT+NB_COEFF+clog2(N_TAPS); it cannot overflow.
- Alignment drops D = NBF_INPUT+NBF_COEFF-NBF_OUTPUT LSBs.
- If ROUND=1 and D>0, add 2^(D-1) before dropping.
- The result is saturated to the NB_OUTPUT range: [-2^(NB_OUTPUT-1), 2^(NB_OUTPUT-1)-1]. o_sat=1 when clipped.

Coefficient writes:
- Writes commit on the edge only when state==IDLE. Writes in MAC/OUT are ignored.
- A write on the same edge as an accept is used by that sample.
- An out-of-range address (≥ N_TAPS) is ignored.

Enable:
- i_en=0 freezes the FSM, counter, accumulator, delay line, o_valid, o_os_data and o_sat (o_valid held, not re-pulsed). Coefficient writes are blocked. o_ready=0.
- Resuming with i_en=1 continues exactly where it stopped.

Clear:
- i_clear=1 (requires i_en=1) zeros the delay line and accumulator, sets state → IDLE and o_valid ← 0.
- Coefficients and o_os_data are kept.
- i_clear takes priority over accept and over MAC progress.

Test Plan:
- Impulse: defaults; write c[k]=8*(k+1) for k=0..7; feed 4096 then 7 zeros → o_os_data = 256, 512, 768, …, 2048; the next zero input gives 0; o_sat=0 throughout.
- Saturation: all c=127; hold input 8191 for 8 samples → 8th output 8191 with o_sat=1. Repeat with input -8192 → -8192, o_sat=1.
- Rounding: c[0]=1, others 0. With ROUND=1: input 64 → 1, input -64 → 0. With ROUND=0: input 64 → 0, input -64 → -1.
- Handshake/throughput: hold i_valid=1 continuously → accept every 10 cycles; o_valid 9 edges after each accept; o_ready low for 9 cycles per sample. Coefficient write during MAC → no effect on any output.
- Enable stall: drop i_en for 5 cycles mid-MAC → same o_os_data as the unstalled run, o_valid delayed exactly 5 cycles; o_ready=0 during the stall.
- Reset/clear: assert i_rst_n=0 mid-MAC → all outputs 0 immediately; a following impulse with unwritten coefficients → outputs 0. Assert i_clear mid-MAC → no o_valid for that sample; next output is computed from a zeroed history.
